// File: rtl/seg_display_arbiter_pkg.sv
// ============================================================================
// seg_disp_pkg : shared widths and FSM encoding for seg_display_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package seg_disp_pkg;

    localparam int VALUE_W = 16;
    localparam int DIGIT_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/seg_display_arbiter_rr_pick.sv
// ============================================================================
// rr_pick : combinational round-robin picker, first set bit after ptr_i
// Revision 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    input  logic [N-1:0]         excl_i,
    output logic [N-1:0]         onehot_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 valid_o
);

    localparam int IW = $clog2(N);

    // Scan from farthest to nearest so the nearest candidate after ptr_i wins.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        for (int k = N; k >= 1; k--) begin
            int j;
            j = (int'(ptr_i) + k) % N;
            if (req_i[j] && !excl_i[j]) begin
                onehot_o    = '0;
                onehot_o[j] = 1'b1;
                idx_o       = IW'(j);
                valid_o     = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/seg_display_arbiter.sv
// ============================================================================
// seg_display_arbiter : round-robin time-sharing of one 4-digit display
// Revision 1.0
// ============================================================================
`default_nettype none

module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [VALUE_W*NUM_REQ-1:0] data,
    output logic [NUM_REQ-1:0]         grant,
    output logic [VALUE_W-1:0]         disp_value,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD   = CW'(HOLD_CYCLES - 1);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        last_q, last_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [VALUE_W-1:0]   disp_q, disp_d;

    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IW-1:0]        pick_idx;
    logic                 pick_valid;
    logic [NUM_REQ-1:0]   pick_excl;
    logic                 owner_req;
    logic [VALUE_W-1:0]   owner_data;
    logic [VALUE_W-1:0]   pick_data;

    // The current owner never competes in its own handover.
    assign pick_excl  = (state_q == HOLD) ? grant_q : '0;
    assign owner_req  = req[owner_q];
    assign owner_data = data[owner_q*VALUE_W +: VALUE_W];
    assign pick_data  = data[pick_idx*VALUE_W +: VALUE_W];

    rr_pick #(
        .N (NUM_REQ)
    ) u_rr_pick (
        .req_i    (req),
        .ptr_i    (last_q),
        .excl_i   (pick_excl),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = HOLD;
            HOLD:    if (!owner_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = RELOAD;
                    disp_d  = pick_data;
                end
            end
            HOLD: begin
                // Release takes precedence over expiry; the display keeps its value.
                if (!owner_req) begin
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (cnt_q == '0 && pick_valid) begin
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = RELOAD;
                    disp_d  = pick_data;
                end else if (cnt_q == '0) begin
                    cnt_d  = RELOAD;
                    disp_d = owner_data;
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    disp_d = owner_data;
                end
            end
            default: begin
                grant_d = '0;
            end
        endcase
    end

    assign grant      = grant_q;
    assign disp_value = disp_q;
    assign busy       = (state_q == HOLD);

endmodule

`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
// ============================================================================
// tb_seg_display_arbiter : directed table, corner sequences, random vs model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_seg_display_arbiter;

    localparam int N = 4;
    localparam int H = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [63:0]   data;
    logic [N-1:0]  grant;
    logic [15:0]   disp_value;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Reference model: owner index, cycles owned since grant/reload, last winner.
    int          m_owner;
    int          m_held;
    int          m_last;
    logic [15:0] m_disp;

    seg_display_arbiter #(
        .NUM_REQ     (N),
        .HOLD_CYCLES (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data       (data),
        .grant      (grant),
        .disp_value (disp_value),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [63:0] data;
        logic [3:0]  exp_grant;
        logic [15:0] exp_disp;
        logic        exp_busy;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [3:0] r, input int lst, input int excl);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (lst + k) % N;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] dsel(input logic [63:0] d, input int i);
        return d[16*i +: 16];
    endfunction

    function automatic logic [3:0] oh(input int i);
        logic [3:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = N - 1;
        m_disp  = 16'h0000;
    endtask

    task automatic model_update();
        int w;
        if (m_owner < 0) begin
            w = rr(req, m_last, -1);
            if (w >= 0) begin
                m_owner = w; m_last = w; m_held = 1; m_disp = dsel(data, w);
            end
        end else if (!req[m_owner]) begin
            m_owner = -1;
            m_held  = 0;
        end else if (m_held == H) begin
            w = rr(req, m_last, m_owner);
            if (w >= 0) begin
                m_owner = w; m_last = w; m_held = 1; m_disp = dsel(data, w);
            end else begin
                m_held = 1; m_disp = dsel(data, m_owner);
            end
        end else begin
            m_held++;
            m_disp = dsel(data, m_owner);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        req  = '0;
        data = '0;
        rst  = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vt[10];

    initial begin
        vt[0] = '{4'b0001, 64'h0000_0000_0000_1234, 4'b0001, 16'h1234, 1'b1};
        vt[1] = '{4'b0001, 64'h0000_0000_0000_ABCD, 4'b0001, 16'hABCD, 1'b1};
        vt[2] = '{4'b0001, 64'h0000_0000_0000_00FF, 4'b0001, 16'h00FF, 1'b1};
        vt[3] = '{4'b1001, 64'h5555_0000_0000_00FF, 4'b0001, 16'h00FF, 1'b1};
        vt[4] = '{4'b1001, 64'h5555_0000_0000_00FF, 4'b1000, 16'h5555, 1'b1};
        vt[5] = '{4'b1000, 64'h5556_0000_0000_00FF, 4'b1000, 16'h5556, 1'b1};
        vt[6] = '{4'b0000, 64'h7777_0000_0000_00FF, 4'b0000, 16'h5556, 1'b0};
        vt[7] = '{4'b0001, 64'h0000_0000_0000_1111, 4'b0001, 16'h1111, 1'b1};
        vt[8] = '{4'b0100, 64'h0000_2222_0000_1111, 4'b0000, 16'h1111, 1'b0};
        vt[9] = '{4'b0100, 64'h0000_2222_0000_1111, 4'b0100, 16'h2222, 1'b1};

        do_reset();
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_disp", 32'(disp_value), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);

        for (int v = 0; v < 10; v++) begin
            req  = vt[v].req;
            data = vt[v].data;
            step();
            chk($sformatf("vec%0d_grant", v), 32'(grant), 32'(vt[v].exp_grant));
            chk($sformatf("vec%0d_disp", v), 32'(disp_value), 32'(vt[v].exp_disp));
            chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vt[v].exp_busy));
        end

        // Contention: owners 0,1,3 in turn, each exactly H cycles, no gaps.
        do_reset();
        req  = 4'b1011;
        data = 64'hD003_C002_B001_A000;
        step();
        for (int c = 0; c < 24; c++) begin
            int o;
            o = (c / H) % 3;
            o = (o == 2) ? 3 : o;
            chk("contention_grant", 32'(grant), 32'(oh(o)));
            chk("contention_disp", 32'(disp_value), 32'(dsel(data, o)));
            step();
        end

        // Sole holder keeps the display across counter reloads.
        do_reset();
        req  = 4'b0100;
        data = 64'h0000_4242_0000_0000;
        step();
        for (int c = 0; c < 12; c++) begin
            chk("sole_grant", 32'(grant), 32'h4);
            chk("sole_busy", 32'(busy), 32'h1);
            step();
        end

        // Asynchronous reset between edges, then requester 0 has priority.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_grant", 32'(grant), 32'h0);
        chk("async_disp", 32'(disp_value), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        model_reset();
        @(negedge clk);
        rst  = 1'b0;
        req  = 4'b1111;
        data = 64'h4444_3333_2222_1111;
        step();
        chk("after_async_grant", 32'(grant), 32'h1);
        chk("after_async_disp", 32'(disp_value), 32'h1111);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            if ($urandom_range(0, 2) == 0)
                data = {$urandom(), $urandom()};
            step();
            chk("rand_grant", 32'(grant), 32'(oh(m_owner)));
            chk("rand_disp", 32'(disp_value), 32'(m_disp));
            chk("rand_busy", 32'(busy), 32'(m_owner >= 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
